// File: rtl/arb_req_agent.sv
// rtl/arb_req_agent.sv - requester-side agent: per-client FIFOs, Req/Grant handshake, shared output bus
module arb_req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Contents need no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

module arb_req_agent #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          in_valid,
    output logic [NUM_REQ-1:0]          in_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   in_data,
    output logic [NUM_REQ-1:0]          Req,
    input  logic [NUM_REQ-1:0]          Grant,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(NUM_REQ)-1:0]  out_src,
    output logic                        err_proto,
    output logic [NUM_REQ-1:0]          starve
);
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  count      [NUM_REQ];
    logic [DATA_W-1:0] head       [NUM_REQ];
    logic [STV_W-1:0]  starve_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;

    logic              grant_one_hot;
    logic              grant_ok;
    logic              grant_bad;
    logic [SRC_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_data;

    assign grant_one_hot = (Grant != '0) && ((Grant & (Grant - NUM_REQ'(1))) == '0);
    assign grant_ok      = grant_one_hot && ((Grant & Req) != '0);
    assign grant_bad     = (Grant != '0) && !grant_ok;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_client
        // in_ready looks only at the registered count, so a full FIFO never
        // accepts a word even when it is popped in the same cycle.
        assign in_ready[g] = !rst && (count[g] != CNT_W'(FIFO_DEPTH));
        assign Req[g]      = (count[g] != '0);
        assign push[g]     = in_valid[g] && in_ready[g];
        assign pop[g]      = grant_ok && Grant[g];
        assign starve[g]   = (starve_cnt[g] == STV_W'(STARVE_LIMIT));

        arb_req_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .wdata (in_data[g*DATA_W +: DATA_W]),
            .pop   (pop[g]),
            .rdata (head[g]),
            .count (count[g])
        );
    end

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (Grant[i]) begin
                sel_idx  = SRC_W'(i);
                sel_data = head[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            err_proto <= 1'b0;
        end else begin
            out_valid <= grant_ok;
            if (grant_ok) begin
                out_data <= sel_data;
                out_src  <= sel_idx;
            end
            if (grant_bad) begin
                err_proto <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                starve_cnt[i] <= '0;
            end else if (Req[i] && !Grant[i]) begin
                if (starve_cnt[i] != STV_W'(STARVE_LIMIT)) begin
                    starve_cnt[i] <= starve_cnt[i] + STV_W'(1);
                end
            end else begin
                starve_cnt[i] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_arb_req_agent.sv
// tb/tb_arb_req_agent.sv - directed vector bench for arb_req_agent
module tb_arb_req_agent;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  Req;
    logic [3:0]  Grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        err_proto;
    logic [3:0]  starve;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    arb_req_agent #(
        .NUM_REQ      (4),
        .DATA_W       (8),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .Req       (Req),
        .Grant     (Grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .err_proto (err_proto),
        .starve    (starve)
    );

    // One record = inputs for a cycle plus outputs expected during that cycle.
    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic [31:0] id;
        logic [3:0]  gr;
        logic [3:0]  rdy;
        logic [3:0]  req;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  os;
        logic        err;
        logic [3:0]  stv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] iv, logic [31:0] id, logic [3:0] gr,
                                logic [3:0] rdy, logic [3:0] req, logic ov, logic [7:0] od,
                                logic [1:0] os, logic err, logic [3:0] stv);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = id; v.gr = gr;
        v.rdy = rdy; v.req = req; v.ov = ov; v.od = od; v.os = os; v.err = err; v.stv = stv;
        return v;
    endfunction

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst      = v.rst;
        in_valid = v.iv;
        in_data  = v.id;
        Grant    = v.gr;
        #1;
        chk("in_ready", tag, 32'(in_ready), 32'(v.rdy));
        if (!v.rst) begin
            chk("Req", tag, 32'(Req), 32'(v.req));
        end
        chk("out_valid", tag, 32'(out_valid), 32'(v.ov));
        chk("out_data",  tag, 32'(out_data),  32'(v.od));
        chk("out_src",   tag, 32'(out_src),   32'(v.os));
        chk("err_proto", tag, 32'(err_proto), 32'(v.err));
        chk("starve",    tag, 32'(starve),    32'(v.stv));
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_data = '0; Grant = '0;

        // reset state, then reset mid-stream with 3 words in client 2
        tbl.push_back(mk(1, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h4, 32'h00210000, 4'h0, 4'hF, 4'h0, 0, 8'h00, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h4, 32'h00220000, 4'h0, 4'hF, 4'h4, 0, 8'h00, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h4, 32'h00230000, 4'h0, 4'hF, 4'h4, 0, 8'h00, 0, 0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 32'h0,        4'h0, 4'h0, 4'h4, 0, 8'h00, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h0, 0, 8'h00, 0, 0, 4'h0));
        // single client 1, two non-adjacent grants
        tbl.push_back(mk(0, 4'h2, 32'h0000A100, 4'h0, 4'hF, 4'h0, 0, 8'h00, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h2, 32'h0000A200, 4'h0, 4'hF, 4'h2, 0, 8'h00, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h2, 0, 8'h00, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h2, 4'hF, 4'h2, 0, 8'h00, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h2, 1, 8'hA1, 1, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h2, 4'hF, 4'h2, 0, 8'hA1, 1, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h0, 1, 8'hA2, 1, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h0, 0, 8'hA2, 1, 0, 4'h0));
        // fill client 0, hold in_valid at full, then wrap and drain
        tbl.push_back(mk(0, 4'h1, 32'h00000001, 4'h0, 4'hF, 4'h0, 0, 8'hA2, 1, 0, 4'h0));
        tbl.push_back(mk(0, 4'h1, 32'h00000002, 4'h0, 4'hF, 4'h1, 0, 8'hA2, 1, 0, 4'h0));
        tbl.push_back(mk(0, 4'h1, 32'h00000003, 4'h0, 4'hF, 4'h1, 0, 8'hA2, 1, 0, 4'h0));
        tbl.push_back(mk(0, 4'h1, 32'h00000004, 4'h0, 4'hF, 4'h1, 0, 8'hA2, 1, 0, 4'h0));
        tbl.push_back(mk(0, 4'h1, 32'h00000005, 4'h0, 4'hE, 4'h1, 0, 8'hA2, 1, 0, 4'h0));
        tbl.push_back(mk(0, 4'h1, 32'h00000005, 4'h1, 4'hE, 4'h1, 0, 8'hA2, 1, 0, 4'h0));
        tbl.push_back(mk(0, 4'h1, 32'h00000005, 4'h0, 4'hF, 4'h1, 1, 8'h01, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h1, 4'hE, 4'h1, 0, 8'h01, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h1, 32'h00000006, 4'h0, 4'hF, 4'h1, 1, 8'h02, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h1, 4'hE, 4'h1, 0, 8'h02, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h1, 1, 8'h03, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h1, 4'hF, 4'h1, 0, 8'h03, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h1, 1, 8'h04, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h1, 4'hF, 4'h1, 0, 8'h04, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h1, 4'hF, 4'h1, 1, 8'h05, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h0, 1, 8'h06, 0, 0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h0, 0, 8'h06, 0, 0, 4'h0));

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // concurrent push/pop on client 3 holding two words
        apply(mk(0, 4'h8, 32'h31000000, 4'h0, 4'hF, 4'h0, 0, 8'h06, 0, 0, 4'h0), "cc0");
        apply(mk(0, 4'h8, 32'h32000000, 4'h0, 4'hF, 4'h8, 0, 8'h06, 0, 0, 4'h0), "cc1");
        apply(mk(0, 4'h8, 32'h55000000, 4'h8, 4'hF, 4'h8, 0, 8'h06, 0, 0, 4'h0), "cc2");
        apply(mk(0, 4'h0, 32'h0,        4'h8, 4'hF, 4'h8, 1, 8'h31, 3, 0, 4'h0), "cc3");
        apply(mk(0, 4'h0, 32'h0,        4'h8, 4'hF, 4'h8, 1, 8'h32, 3, 0, 4'h0), "cc4");
        apply(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h0, 1, 8'h55, 3, 0, 4'h0), "cc5");
        apply(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h0, 0, 8'h55, 3, 0, 4'h0), "cc6");

        // multi-bit grant, then grant to an empty client after reset
        apply(mk(0, 4'h3, 32'h00001A0A, 4'h0, 4'hF, 4'h0, 0, 8'h55, 3, 0, 4'h0), "il0");
        apply(mk(0, 4'h0, 32'h0,        4'h3, 4'hF, 4'h3, 0, 8'h55, 3, 0, 4'h0), "il1");
        apply(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h3, 0, 8'h55, 3, 1, 4'h0), "il2");
        apply(mk(0, 4'h0, 32'h0,        4'h1, 4'hF, 4'h3, 0, 8'h55, 3, 1, 4'h0), "il3");
        apply(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h2, 1, 8'h0A, 0, 1, 4'h0), "il4");
        apply(mk(1, 4'h0, 32'h0,        4'h0, 4'h0, 4'h2, 0, 8'h0A, 0, 1, 4'h0), "il5");
        apply(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h0, 0, 8'h00, 0, 0, 4'h0), "il6");
        apply(mk(0, 4'h0, 32'h0,        4'h4, 4'hF, 4'h0, 0, 8'h00, 0, 0, 4'h0), "il7");
        apply(mk(0, 4'h0, 32'h0,        4'h0, 4'hF, 4'h0, 0, 8'h00, 0, 1, 4'h0), "il8");

        // starvation: flag from the 9th ungranted cycle, saturates, clears after grant
        apply(mk(1, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0, 0, 8'h00, 0, 1, 4'h0), "st_rst");
        apply(mk(0, 4'h1, 32'h000000C0, 4'h0, 4'hF, 4'h0, 0, 8'h00, 0, 0, 4'h0), "st_push");
        for (int k = 1; k <= 8; k++) begin
            apply(mk(0, 4'h0, 32'h0, 4'h0, 4'hF, 4'h1, 0, 8'h00, 0, 0, 4'h0), $sformatf("st_wait%0d", k));
        end
        for (int k = 9; k <= 11; k++) begin
            apply(mk(0, 4'h0, 32'h0, 4'h0, 4'hF, 4'h1, 0, 8'h00, 0, 0, 4'h1), $sformatf("st_flag%0d", k));
        end
        apply(mk(0, 4'h0, 32'h0, 4'h1, 4'hF, 4'h1, 0, 8'h00, 0, 0, 4'h1), "st_grant");
        apply(mk(0, 4'h0, 32'h0, 4'h0, 4'hF, 4'h0, 1, 8'hC0, 0, 0, 4'h0), "st_clear");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/arb_req_agent.md
Name: arb_req_agent

Overview:
- Requester-side counterpart to the 4-way round-robin arbiter.
- Buffers words from NUM_REQ local clients in per-client FIFOs and drives Req[i] while client i has data.
- Consumes the arbiter's Grant vector, popping one word per grant onto a shared output bus.
- Flags protocol violations (illegal grants) and starved requesters.

Parameters:
- NUM_REQ, 4: number of clients; matches the arbiter's Req/Grant width.
- DATA_W, 8: data word width.
- FIFO_DEPTH, 4: words per client FIFO; must be a power of 2 and ≥2.
- STARVE_LIMIT, 8: consecutive requesting-but-ungranted cycles before starve[i] asserts; must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_REQ  per-client write valid.
- in_ready  out  NUM_REQ  per-client write ready.
- in_data  in  NUM_REQ*DATA_W  client i data in bits [i*DATA_W +: DATA_W].
- Req  out  NUM_REQ  request vector to arbiter.
- Grant  in  NUM_REQ  grant vector from arbiter; expected one-hot or zero, one-cycle pulse.
- out_valid  out  1  shared bus word valid.
- out_data  out  DATA_W  shared bus data.
- out_src  out  $clog2(NUM_REQ)  index of the client that sourced out_data.
- err_proto  out  1  sticky protocol-error flag.
- starve  out  NUM_REQ  per-client starvation flag.

Behaviour:
- Reset, applied on a clk edge with rst=1:
  - All FIFOs emptied (pointers and counts = 0); contents discarded even mid-operation.
  - Req=0, out_valid=0, out_data=0, out_src=0, err_proto=0, starve=0, starvation counters=0.
  - in_ready=0 while rst=1; returns to 1 on the first cycle after reset.
- FIFO i is a circular buffer with wrap-around read/write pointers and a 0..FIFO_DEPTH count.
- in_ready[i] = (count_i != FIFO_DEPTH), from the registered count only.
  - A push at full is therefore impossible, even when a pop happens in the same cycle.
- Push on in_valid[i] & in_ready[i].
  - Push and pop in the same cycle leave count unchanged; the data order is preserved.
- Req[i] = (count_i != 0), combinational from the registered count.
  - Stays high during the grant cycle; reflects the decremented count on the next cycle.
- Legal grant cycle: Grant one-hot at bit i with count_i != 0.
  - Pop the head of FIFO i.
  - Next cycle: out_valid=1, out_data = popped word, out_src=i (one-cycle latency).
- Illegal grant cycle: Grant has more than one bit set, or Grant[i]=1 while count_i==0.
  - No FIFO pops in that cycle.
  - err_proto set next cycle and held until reset.
  - out_valid=0 next cycle.
- Grant=0: out_valid=0 next cycle. out_data and out_src hold their last value.
- The shared bus has no backpressure; the consumer must accept every out_valid beat.
- Starvation counter i:
  - Increments (saturating at STARVE_LIMIT) on cycles with Req[i]=1 and Grant[i]=0.
  - Clears to 0 on Grant[i]=1 or Req[i]=0.
  - starve[i] is registered: 1 when counter_i == STARVE_LIMIT.
  - starve[i] clears the cycle after a grant to i or after Req[i] drops.
- Simultaneous events in one cycle:
  - A push to i while Grant[i] pops i: both take effect.
  - Grant[i] and an illegal multi-bit Grant: treated as illegal; no pop.
- No internal state machine beyond the FIFOs, the output register and the counters. Implementation is roughly 150–250 lines.

Test Plan:
- Reset mid-stream: push 3 words to client 2, assert rst for 1 cycle → Req=0, in_ready=0 during reset, in_ready=4'hF the cycle after, out_valid=0, err_proto=0, starve=0.
- Single client: push 0xA1, 0xA2 to client 1, grant 4'b0010 on two non-adjacent cycles → out_valid pulses with out_data 0xA1 then 0xA2, out_src=1 each time; Req[1] drops the cycle after the second grant.
- Fill/wrap: push 4 words to client 0 → in_ready[0]=0 with in_valid[0] held high and no 5th push. Grant once, then push 2 more and drain with 5 more grants → 6 words out in push order (pointers wrap past 3→0).
- Concurrent push/pop: client 3 holds count=2, push 0x55 in the same cycle as Grant=4'b1000 → count stays 2, head word out, 0x55 emerges last.
- Illegal grants: Grant=4'b0011 with both FIFOs non-empty → no pop, out_valid=0, err_proto=1 next cycle and held. Separately, after reset, Grant=4'b0100 with client 2 empty → err_proto=1.
- Starvation: STARVE_LIMIT=8, client 0 holds data with Grant=0 for 8 cycles → starve[0]=1 from the 9th cycle. Then Grant=4'b0001 → starve[0]=0 the cycle after.
